reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Architectural register file, 32 x 32-bit, with a per-register rename tag for the out-of-order core.
- Sits directly downstream of the reorder buffer.
  - Consumes the ROB issue stream (rd, new ROB tag) and the ROB commit stream (rd, ROB id, value).
  - Consumes the ROB flush pulse.
- Serves two combinational source-operand lookups to the decoder.
- Each lookup returns the value, or the ROB tag the operand still waits on.

Parameters:
- ROB_ADDR_W, 4, width of a ROB tag; must equal the ROB index width.
- NUM_REGS, 32, architectural register count; register 0 hard-wired to zero.

Ports:
- clk_in  input  1  clock, rising-edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global stall; low freezes all state.
- flush_in  input  1  misprediction clear from the ROB; drops all rename tags.
- issue_valid  input  1  an instruction writing rd entered the ROB this cycle.
- issue_rd  input  5  destination register of the issuing instruction.
- issue_dep  input  ROB_ADDR_W  ROB tag allocated to it.
- commit_valid  input  1  ROB head retires a register-writing instruction.
- commit_rd  input  5  destination register being retired.
- commit_robid  input  ROB_ADDR_W  ROB id of the retiring entry.
- commit_value  input  32  result to write.
- rs1_idx, rs2_idx  input  5  decoder source register indices.
- rs1_value, rs2_value  output  32  register contents (see bypass).
- rs1_busy, rs2_busy  output  1  operand still pending in the ROB.
- rs1_dep, rs2_dep  output  ROB_ADDR_W  ROB tag producing the operand; 0 when not busy.

Behaviour:
- State: regs[NUM_REGS] 32-bit, busy[NUM_REGS], dep[NUM_REGS].
- Reset (rst_in low, asynchronous): all regs, busy and dep clear to 0. All outputs read 0 as a consequence.
- All updates occur on the rising edge, only when rdy_in=1. With rdy_in=0, every input is ignored and state holds.
- Commit (commit_valid=1, commit_rd!=0):
  - regs[commit_rd] <= commit_value.
  - If dep[commit_rd]==commit_robid, busy/dep are cleared. Otherwise busy/dep are kept, because a newer writer owns the register.
- Issue (issue_valid=1, issue_rd!=0, flush_in=0): busy[issue_rd] <= 1, dep[issue_rd] <= issue_dep.
- Issue and commit to the same rd in the same cycle: the value is written and the issue tag wins (busy=1, dep=issue_dep).
- Flush (flush_in=1):
  - All busy and dep clear to 0.
  - A same-cycle commit is still written to regs; it is architectural.
  - A same-cycle issue is discarded.
- Register 0 never goes busy. It is never written, and reads value 0, busy 0, dep 0.
- Read ports are combinational from current state. They never reflect a same-cycle issue, so an instruction reading its own rd sees the prior producer.
- When busy=0, dep output is forced to 0.
- Latency: an issued tag is visible on read ports the cycle after the issue edge. A committed value is visible the cycle after the commit edge, unless bypass is present.

Optional Feature:
- Macro: RF_COMMIT_BYPASS_EN.
- Defined: the read port forwards a same-cycle commit.
  - Applies when commit_valid=1, commit_rd==rsN_idx and rsN_idx!=0.
  - Then rsN_value=commit_value.
  - rsN_busy is cleared (and dep 0) when dep[rsN_idx]==commit_robid.
  - Bypass applies regardless of flush_in and is gated by rdy_in.
- Undefined: read ports show registered state only, giving one cycle extra operand latency.

Test Plan:
- Reset low mid-run with x5 busy, dep=3 -> all outputs 0 immediately (async). After release, rs1_idx=5 gives value 0, busy 0.
- Issue rd=5 dep=3, then commit rd=5 robid=3 value 0x1234 -> read x5 gives busy 1, dep 3 the cycle after issue; then value 0x1234, busy 0, dep 0 after commit.
- Issue rd=7 dep=2, issue rd=7 dep=4, then commit rd=7 robid=2 value 0xAA -> regs[7]=0xAA, busy stays 1, dep 4.
- Same-cycle commit rd=9 robid=1 value 0x55 (dep matches) plus issue rd=9 dep=6 -> regs[9]=0x55, busy 1, dep 6.
- Three registers busy; flush_in=1 with commit rd=3 value 0x77 and issue rd=8 -> all busy 0, regs[3]=0x77, x8 not busy. Issue/commit to rd=0 -> x0 stays 0, not busy. rdy_in=0 with commit -> no change.
- With RF_COMMIT_BYPASS_EN: x4 busy dep 5; commit rd=4 robid=5 value 0xBEEF, rs2_idx=4 same cycle -> rs2_value 0xBEEF, rs2_busy 0 combinationally. Without the macro: busy 1 that cycle, 0xBEEF next cycle.

Source files
------------

// File: rtl/reg_rename_file_if.sv
// Decoder/ROB-facing bundle of the rename register file: ROB issue, commit and flush streams,
// plus two combinational source-operand lookups.
interface reg_rename_file_if #(parameter int ROB_ADDR_W = 4);
   logic                  rdy_in;
   logic                  flush_in;
   logic                  issue_valid;
   logic [4:0]            issue_rd;
   logic [ROB_ADDR_W-1:0] issue_dep;
   logic                  commit_valid;
   logic [4:0]            commit_rd;
   logic [ROB_ADDR_W-1:0] commit_robid;
   logic [31:0]           commit_value;
   logic [4:0]            rs1_idx;
   logic [4:0]            rs2_idx;
   logic [31:0]           rs1_value;
   logic [31:0]           rs2_value;
   logic                  rs1_busy;
   logic                  rs2_busy;
   logic [ROB_ADDR_W-1:0] rs1_dep;
   logic [ROB_ADDR_W-1:0] rs2_dep;

   modport master (
      output rdy_in, flush_in, issue_valid, issue_rd, issue_dep,
             commit_valid, commit_rd, commit_robid, commit_value, rs1_idx, rs2_idx,
      input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_dep, rs2_dep
   );
   modport slave (
      input  rdy_in, flush_in, issue_valid, issue_rd, issue_dep,
             commit_valid, commit_rd, commit_robid, commit_value, rs1_idx, rs2_idx,
      output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_dep, rs2_dep
   );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags and two combinational read ports.
// Define RF_COMMIT_BYPASS_EN to forward a same-cycle commit onto the read ports.
module reg_rename_file #(
   parameter int ROB_ADDR_W = 4,
   parameter int NUM_REGS   = 32
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   reg_rename_file_if.slave     rf
);
   logic [NUM_REGS-1:0][31:0]           regs_q, regs_d;
   logic [NUM_REGS-1:0]                 busy_q, busy_d;
   logic [NUM_REGS-1:0][ROB_ADDR_W-1:0] dep_q, dep_d;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         regs_q <= '0;
         busy_q <= '0;
         dep_q  <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         dep_q  <= dep_d;
      end
   end

   // Commit first, then flush/issue: an issue to the same rd overrides the commit's tag release.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      dep_d  = dep_q;
      if (rf.rdy_in) begin
         if (rf.commit_valid && rf.commit_rd != 5'd0) begin
            regs_d[rf.commit_rd] = rf.commit_value;
            if (dep_q[rf.commit_rd] == rf.commit_robid) begin
               busy_d[rf.commit_rd] = 1'b0;
               dep_d[rf.commit_rd]  = '0;
            end
         end
         if (rf.flush_in) begin
            busy_d = '0;
            dep_d  = '0;
         end else if (rf.issue_valid && rf.issue_rd != 5'd0) begin
            busy_d[rf.issue_rd] = 1'b1;
            dep_d[rf.issue_rd]  = rf.issue_dep;
         end
      end
   end

   logic [1:0][4:0]            rs_idx;
   logic [1:0][31:0]           rs_val;
   logic [1:0]                 rs_busy;
   logic [1:0][ROB_ADDR_W-1:0] rs_dep;

   assign rs_idx = {rf.rs2_idx, rf.rs1_idx};

   always_comb begin
      rs_val  = '0;
      rs_busy = '0;
      rs_dep  = '0;
      for (int p = 0; p < 2; p++) begin
         if (rs_idx[p] != 5'd0) begin
            rs_val[p]  = regs_q[rs_idx[p]];
            rs_busy[p] = busy_q[rs_idx[p]];
`ifdef RF_COMMIT_BYPASS_EN
            if (rf.rdy_in && rf.commit_valid && rf.commit_rd == rs_idx[p]) begin
               rs_val[p] = rf.commit_value;
               if (dep_q[rs_idx[p]] == rf.commit_robid) rs_busy[p] = 1'b0;
            end
`endif
            if (rs_busy[p]) rs_dep[p] = dep_q[rs_idx[p]];
         end
      end
   end

   assign rf.rs1_value = rs_val[0];
   assign rf.rs2_value = rs_val[1];
   assign rf.rs1_busy  = rs_busy[0];
   assign rf.rs2_busy  = rs_busy[1];
   assign rf.rs1_dep   = rs_dep[0];
   assign rf.rs2_dep   = rs_dep[1];
endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: a vector table replayed through a scoreboard queue,
// plus hand-written reset sequences.
module tb_reg_rename_file;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   reg_rename_file_if #(.ROB_ADDR_W(4)) rf ();
   reg_rename_file #(.ROB_ADDR_W(4), .NUM_REGS(32)) dut (.clk_in(clk), .rst_in(rst_n), .rf(rf.slave));

   initial forever #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rdy, fl, iv;
      logic [4:0]  ird;
      logic [3:0]  idep;
      logic        cv;
      logic [4:0]  crd;
      logic [3:0]  crob;
      logic [31:0] cval;
      logic [4:0]  r1;
      logic [31:0] e1v;
      logic        e1b;
      logic [3:0]  e1d;
      logic [4:0]  r2;
      logic [31:0] e2v;
      logic        e2b;
      logic [3:0]  e2d;
   } vec_t;

   vec_t vt[$];
   vec_t sb[$];

   function automatic vec_t mk(string name, logic rdy, logic fl, logic iv, logic [4:0] ird,
                               logic [3:0] idep, logic cv, logic [4:0] crd, logic [3:0] crob,
                               logic [31:0] cval, logic [4:0] r1, logic [31:0] e1v, logic e1b,
                               logic [3:0] e1d, logic [4:0] r2, logic [31:0] e2v, logic e2b,
                               logic [3:0] e2d);
      vec_t v;
      v.name = name; v.rdy = rdy; v.fl = fl; v.iv = iv; v.ird = ird; v.idep = idep;
      v.cv = cv; v.crd = crd; v.crob = crob; v.cval = cval;
      v.r1 = r1; v.e1v = e1v; v.e1b = e1b; v.e1d = e1d;
      v.r2 = r2; v.e2v = e2v; v.e2b = e2b; v.e2d = e2d;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      rf.rdy_in = v.rdy; rf.flush_in = v.fl;
      rf.issue_valid = v.iv; rf.issue_rd = v.ird; rf.issue_dep = v.idep;
      rf.commit_valid = v.cv; rf.commit_rd = v.crd; rf.commit_robid = v.crob;
      rf.commit_value = v.cval; rf.rs1_idx = v.r1; rf.rs2_idx = v.r2;
   endtask

   task automatic check_ports(vec_t e);
      chk({e.name, ".rs1_value"}, rf.rs1_value, e.e1v);
      chk({e.name, ".rs1_busy"},  {31'd0, rf.rs1_busy}, {31'd0, e.e1b});
      chk({e.name, ".rs1_dep"},   {28'd0, rf.rs1_dep}, {28'd0, e.e1d});
      chk({e.name, ".rs2_value"}, rf.rs2_value, e.e2v);
      chk({e.name, ".rs2_busy"},  {31'd0, rf.rs2_busy}, {31'd0, e.e2b});
      chk({e.name, ".rs2_dep"},   {28'd0, rf.rs2_dep}, {28'd0, e.e2d});
   endtask

   localparam logic [31:0] BYP_V = `ifdef RF_COMMIT_BYPASS_EN 32'hBEEF `else 32'h0 `endif;
   localparam logic        BYP_B = `ifdef RF_COMMIT_BYPASS_EN 1'b0 `else 1'b1 `endif;
   localparam logic [3:0]  BYP_D = `ifdef RF_COMMIT_BYPASS_EN 4'd0 `else 4'd5 `endif;

   initial begin
      vec_t e;
      vec_t idle;
      // Each row: inputs for one cycle, and the read-port values expected before that cycle's edge.
      vt.push_back(mk("iss5",    1,0, 1,5,3, 0,0,0,0,          5,0,0,0,         0,0,0,0));
      vt.push_back(mk("see5",    1,0, 0,0,0, 0,0,0,0,          5,0,1,3,         0,0,0,0));
      vt.push_back(mk("cmt5",    1,0, 0,0,0, 1,5,3,32'h1234,   7,0,0,0,         0,0,0,0));
      vt.push_back(mk("rd5",     1,0, 0,0,0, 0,0,0,0,          5,32'h1234,0,0,  7,0,0,0));
      vt.push_back(mk("iss7a",   1,0, 1,7,2, 0,0,0,0,          5,32'h1234,0,0,  9,0,0,0));
      vt.push_back(mk("iss7b",   1,0, 1,7,4, 0,0,0,0,          7,0,1,2,         0,0,0,0));
      vt.push_back(mk("cmt7",    1,0, 0,0,0, 1,7,2,32'hAA,     5,32'h1234,0,0,  0,0,0,0));
      vt.push_back(mk("rd7",     1,0, 0,0,0, 0,0,0,0,          7,32'hAA,1,4,    0,0,0,0));
      vt.push_back(mk("iss9",    1,0, 1,9,1, 0,0,0,0,          0,0,0,0,         0,0,0,0));
      vt.push_back(mk("ci9",     1,0, 1,9,6, 1,9,1,32'h55,     7,32'hAA,1,4,    0,0,0,0));
      vt.push_back(mk("rd9",     1,0, 0,0,0, 0,0,0,0,          9,32'h55,1,6,    7,32'hAA,1,4));
      vt.push_back(mk("iss3",    1,0, 1,3,7, 0,0,0,0,          9,32'h55,1,6,    0,0,0,0));
      vt.push_back(mk("flush",   1,1, 1,8,5, 1,3,0,32'h77,     9,32'h55,1,6,    7,32'hAA,1,4));
      vt.push_back(mk("postfl",  1,0, 0,0,0, 0,0,0,0,          3,32'h77,0,0,    8,0,0,0));
      vt.push_back(mk("postfl2", 1,0, 0,0,0, 0,0,0,0,          7,32'hAA,0,0,    9,32'h55,0,0));
      vt.push_back(mk("x0wr",    1,0, 1,0,3, 1,0,0,32'hDEAD,   0,0,0,0,         0,0,0,0));
      vt.push_back(mk("x0rd",    1,0, 0,0,0, 0,0,0,0,          0,0,0,0,         5,32'h1234,0,0));
      vt.push_back(mk("stall",   0,0, 1,6,2, 1,5,0,32'hFFFF,   5,32'h1234,0,0,  6,0,0,0));
      vt.push_back(mk("stallchk",1,0, 0,0,0, 0,0,0,0,          5,32'h1234,0,0,  6,0,0,0));
      vt.push_back(mk("iss4",    1,0, 1,4,5, 0,0,0,0,          4,0,0,0,         0,0,0,0));
      vt.push_back(mk("byp",     1,0, 0,0,0, 1,4,5,32'hBEEF,   5,32'h1234,0,0,  4,BYP_V,BYP_B,BYP_D));
      vt.push_back(mk("byp2",    1,0, 0,0,0, 0,0,0,0,          4,32'hBEEF,0,0,  0,0,0,0));

      idle = mk("idle", 1,0, 0,0,0, 0,0,0,0, 5,0,0,0, 7,0,0,0);
      drive(idle);
      #2;
      check_ports(idle);                       // held in reset
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         @(negedge clk);
         drive(vt[i]);
         sb.push_back(vt[i]);
         #1;
         e = sb.pop_front();
         check_ports(e);
      end

      // Asynchronous reset mid-run while x5 is busy on tag 3.
      @(negedge clk);
      drive(mk("rst_iss", 1,0, 1,5,3, 0,0,0,0, 5,0,0,0, 0,0,0,0));
      @(negedge clk);
      drive(mk("rst_hold", 1,0, 0,0,0, 0,0,0,0, 5,0,0,0, 7,0,0,0));
      #1;
      check_ports(mk("pre_rst", 1,0, 0,0,0, 0,0,0,0, 5,32'h1234,1,3, 7,32'hAA,0,0));
      #1;
      rst_n = 1'b0;
      #1;
      check_ports(mk("in_rst", 1,0, 0,0,0, 0,0,0,0, 5,0,0,0, 7,0,0,0));
      @(negedge clk);
      rst_n = 1'b1;
      drive(mk("post_rst", 1,0, 0,0,0, 0,0,0,0, 5,0,0,0, 9,0,0,0));
      #1;
      check_ports(mk("post_rst", 1,0, 0,0,0, 0,0,0,0, 5,0,0,0, 9,0,0,0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
